// File: rtl/fifo_chn_scheduler_pkg.sv
// Shared constants and helpers for the channel scheduler and its per-channel buffers.
package fifo_chn_scheduler_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int CHN_BUF_DEPTH = 4;
  localparam int CHN_BUF_AW    = 2;
  localparam int CHN_CNT_W     = 3;
  localparam logic [CHN_CNT_W-1:0] CHN_BUF_FULL = 3'd4;

  // Channel index width, never narrower than one bit.
  function automatic int chn_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chn_buf_4x16.sv
// Four-entry single-clock FIFO; absorbs one channel's strobed words until the arbiter drains them.
module chn_buf_4x16
  import fifo_chn_scheduler_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 we,
  input  logic                 re,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [CHN_CNT_W-1:0] count,
  output logic                 full_drop
);

  logic [W-1:0]            mem [CHN_BUF_DEPTH];
  logic [CHN_BUF_AW-1:0]   wr_ptr, rd_ptr;
  logic                    full, wr_ok, rd_ok;

  assign full = (count == CHN_BUF_FULL);
  // A read in the same cycle frees the slot, so a full buffer still accepts.
  assign wr_ok     = we && !rst && !flush && (!full || re);
  assign rd_ok     = re && !rst && !flush && (count != '0);
  assign full_drop = we && !rst && !flush && full && !re;
  assign dout      = mem[rd_ptr];

  always_ff @(posedge mclk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CHN_CNT_W'(wr_ok) - CHN_CNT_W'(rd_ok);
    end
  end

  always_ff @(posedge mclk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fifo_chn_scheduler.sv
// Round-robin merge of NCH buffered word streams onto one tagged output bus.
module fifo_chn_scheduler #(
  parameter int NCH        = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CHN_BITS   = fifo_chn_scheduler_pkg::chn_bits(NCH)
) (
  input  logic                      mclk,
  input  logic                      rst,
  input  logic [NCH*DATA_WIDTH-1:0] din,
  input  logic [NCH-1:0]            din_stb,
  input  logic [NCH-1:0]            chn_en,
  input  logic [NCH-1:0]            clr_overflow,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [CHN_BITS-1:0]       dout_chn,
  output logic                      dout_stb,
  output logic [NCH-1:0]            overflow
);
  import fifo_chn_scheduler_pkg::*;

  logic [NCH-1:0][DATA_WIDTH-1:0] head;
  logic [NCH-1:0][CHN_CNT_W-1:0]  count;
  logic [NCH-1:0]                 cand, re, full_drop;
  logic [CHN_BITS-1:0]            last_grant, grant_idx;
  logic                           grant_vld;

  for (genvar i = 0; i < NCH; i++) begin : g_chn
    chn_buf_4x16 #(.W(DATA_WIDTH)) u_buf (
      .mclk      (mclk),
      .rst       (rst),
      .flush     (!chn_en[i]),
      .we        (din_stb[i]),
      .re        (re[i]),
      .din       (din[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout      (head[i]),
      .count     (count[i]),
      .full_drop (full_drop[i])
    );
    assign cand[i] = chn_en[i] && (count[i] != '0);
    assign re[i]   = grant_vld && (grant_idx == CHN_BITS'(i));
  end

  // Search begins just past the last winner so every busy channel gets its turn.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_grant) + k) % NCH;
      if (!grant_vld && cand[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CHN_BITS'(idx);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      dout       <= '0;
      dout_chn   <= '0;
      dout_stb   <= 1'b0;
      last_grant <= CHN_BITS'(NCH - 1);
      overflow   <= '0;
    end else begin
      dout_stb <= grant_vld;
      if (grant_vld) begin
        dout       <= head[grant_idx];
        dout_chn   <= grant_idx;
        last_grant <= grant_idx;
      end
      for (int i = 0; i < NCH; i++) begin
        if (full_drop[i])         overflow[i] <= 1'b1;
        else if (clr_overflow[i]) overflow[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_chn_scheduler.sv
// Scoreboard bench: queue-based reference model feeds expectations, a negedge monitor checks outputs.
module tb_fifo_chn_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 16;

  logic                     mclk = 1'b0;
  logic                     rst;
  logic [NCH-1:0][DW-1:0]   dwords;
  logic [NCH*DW-1:0]        din;
  logic [NCH-1:0]           din_stb, chn_en, clr_overflow;
  logic [DW-1:0]            dout;
  logic [1:0]               dout_chn;
  logic                     dout_stb;
  logic [NCH-1:0]           overflow;

  assign din = dwords;

  fifo_chn_scheduler #(.NCH(NCH), .DATA_WIDTH(DW), .CHN_BITS(2)) dut (
    .mclk(mclk), .rst(rst), .din(din), .din_stb(din_stb), .chn_en(chn_en),
    .clr_overflow(clr_overflow), .dout(dout), .dout_chn(dout_chn),
    .dout_stb(dout_stb), .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int ch; int cyc; } exp_t;
  exp_t           sbq[$];
  bit             stb_at[int];
  bit             rst_at[int];
  logic [NCH-1:0] ovf_at[int];

  logic [DW-1:0]  mq[NCH][$];
  bit             mov[NCH];
  int             lg;
  int             tests = 0, fails = 0;

  // Reference: per-channel word queues, round-robin pick from the queues as they stand before the edge.
  task automatic model(input bit r, input logic [NCH-1:0] stb, en, clr,
                       input logic [NCH-1:0][DW-1:0] d);
    int g, j, t;
    logic [NCH-1:0] ov;
    exp_t e;
    t = cyc + 1;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin mq[i].delete(); mov[i] = 0; end
      lg = NCH - 1;
      stb_at[t] = 0; rst_at[t] = 1; ovf_at[t] = '0;
      return;
    end
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      j = (lg + k) % NCH;
      if (g < 0 && en[j] && mq[j].size() > 0) g = j;
    end
    stb_at[t] = (g >= 0);
    if (g >= 0) begin
      e.d = mq[g].pop_front(); e.ch = g; e.cyc = t;
      sbq.push_back(e);
      lg = g;
    end
    for (int i = 0; i < NCH; i++) begin
      bit drop;
      drop = 0;
      if (!en[i]) mq[i].delete();
      else if (stb[i]) begin
        if (mq[i].size() < 4) mq[i].push_back(d[i]);
        else drop = 1;
      end
      if (drop) mov[i] = 1;
      else if (clr[i]) mov[i] = 0;
      ov[i] = mov[i];
    end
    ovf_at[t] = ov;
  endtask

  task automatic step(input bit r, input logic [NCH-1:0] stb, en, clr,
                      input logic [NCH-1:0][DW-1:0] d);
    rst = r; din_stb = stb; chn_en = en; clr_overflow = clr; dwords = d;
    model(r, stb, en, clr, d);
    @(posedge mclk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '1, '0, '0);
  endtask

  function automatic logic [NCH-1:0][DW-1:0] rnd_words();
    logic [NCH-1:0][DW-1:0] d;
    for (int i = 0; i < NCH; i++) d[i] = DW'($urandom);
    return d;
  endfunction

  always @(negedge mclk) begin
    if (stb_at.exists(cyc)) begin
      tests++;
      if (dout_stb !== stb_at[cyc]) begin
        fails++;
        $display("FAIL stb cyc=%0d got=%0b exp=%0b", cyc, dout_stb, stb_at[cyc]);
      end
      if (stb_at[cyc] && sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        if (dout !== e.d || dout_chn !== 2'(e.ch) || e.cyc != cyc) begin
          fails++;
          $display("FAIL data cyc=%0d got=%h/ch%0d exp=%h/ch%0d@%0d",
                   cyc, dout, dout_chn, e.d, e.ch, e.cyc);
        end
      end
    end
    if (ovf_at.exists(cyc)) begin
      tests++;
      if (overflow !== ovf_at[cyc]) begin
        fails++;
        $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, ovf_at[cyc]);
      end
    end
    if (rst_at.exists(cyc)) begin
      tests++;
      if (dout !== '0 || dout_chn !== '0) begin
        fails++;
        $display("FAIL reset_out cyc=%0d got=%h/%0d exp=0/0", cyc, dout, dout_chn);
      end
    end
  end

  initial begin
    logic [NCH-1:0][DW-1:0] d;
    logic [NCH-1:0] s, en, cl;
    bit r;
    lg = NCH - 1;
    step(1, '0, '1, '0, '0);
    step(1, '0, '1, '0, '0);
    while (cyc < 9) idle(1);

    // single word on channel 2
    d = '0; d[2] = 16'hA5A5;
    step(0, 4'b0100, '1, '0, d);
    idle(4);

    // one word per channel in the same cycle
    for (int i = 0; i < NCH; i++) d[i] = DW'(16'h1000 + i);
    step(0, '1, '1, '0, d);
    idle(6);

    // channel 1 bursts 6 words while the rest stream
    for (int t = 0; t < 10; t++) step(0, (t < 6) ? 4'b1111 : 4'b1101, '1, '0, rnd_words());
    idle(20);
    step(0, '0, '1, '1, '0);

    // overflow clear without and with a coincident drop
    for (int t = 0; t < 6; t++) step(0, 4'b1001, '1, '0, rnd_words());
    idle(8);
    step(0, '0, '1, 4'b1000, '0);
    for (int t = 0; t < 6; t++) step(0, 4'b1001, '1, 4'b1000, rnd_words());
    idle(8);
    step(0, '0, '1, '1, '0);

    // disable channel 0 while it holds words
    for (int t = 0; t < 4; t++) step(0, '1, '1, '0, rnd_words());
    step(0, '0, 4'b1110, '0, '0);
    for (int t = 0; t < 3; t++) step(0, 4'b0001, '1, '0, rnd_words());
    idle(20);

    // reset with words pending, then channel 0 must win first
    for (int t = 0; t < 2; t++) step(0, '1, '1, '0, rnd_words());
    step(1, '1, '1, '0, rnd_words());
    step(0, 4'b1001, '1, '0, rnd_words());
    idle(6);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      r = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NCH; i++) begin
        s[i]  = ($urandom_range(0, 99) < 35);
        en[i] = ($urandom_range(0, 99) >= 5);
        cl[i] = ($urandom_range(0, 99) < 5);
      end
      step(r, s, en, cl, rnd_words());
    end
    idle(12);

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0 words left", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
